fdiv: RTL and testbench
=======================

# fdiv

Iterative single-precision floating-point divider for the FPU datapath, sitting beside `fadd` and sharing its operand format. It computes `y = x1 / x2` with one quotient bit per cycle and round-to-nearest-even. It uses valid/ready handshakes on the input and output sides so that it can be stalled by downstream writeback. Denormals are flushed to zero on input and output, which matches the adder.

## Interface
- No parameters.
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  divider idle; an operand pair is accepted when `in_valid && in_ready`.
- `x1`  in  32  dividend: IEEE-754 single `{s,e[7:0],m[22:0]}`.
- `x2`  in  32  divisor, same format.
- `out_valid`  out  1  result valid; held until it is accepted.
- `out_ready`  in  1  consumer accepts the result.
- `y`  out  32  quotient.
- `ovf`  out  1  result overflowed to ±inf; valid together with `y`.
- `dbz`  out  1  finite nonzero dividend divided by zero; valid together with `y`.

## Operation
- States: IDLE, DIV, ROUND, DONE.
  - IDLE→DIV on accept, or IDLE→ROUND for a special case (see Configuration).
  - DIV→ROUND when the iteration counter reaches 0.
  - ROUND→DONE.
  - DONE→IDLE on `out_valid && out_ready`.
- Handshake signals:
  - `in_ready` = (state==IDLE).
  - `out_valid` = (state==DONE).
  - No input is accepted in the same cycle as an output handshake.
- On accept, register:
  - sign `s1^s2`;
  - 10-bit signed exponent `e1 - e2 + 127`;
  - dividend `{1,m1}` and divisor `{1,m2}`;
  - counter = 25.
- DIV: restoring division, one bit per cycle, 26 cycles in total. This produces Q = floor(({1,m1}<<25)/{1,m2}), with Q in [2^24, 2^26), plus a remainder.
- Normalization:
  - If Q[25]=1: mantissa=Q[25:2], guard=Q[1], sticky=Q[0] | (rem≠0), exponent unchanged.
  - Otherwise: mantissa=Q[24:1], guard=Q[0], sticky=(rem≠0), exponent−1.
- Rounding (RNE): increment when guard && (sticky || lsb). A mantissa carry-out sets the mantissa to 1.0 and increments the exponent.
- Exponent range after rounding:
  - ≥255 → ±inf (`0x7F800000` with sign), `ovf=1`.
  - ≤0 → ±0 (flush).
- Special operands (exponent 0 means zero, after flushing denormals):
  - Either operand NaN, 0/0, or inf/inf → `0x7FC00000`.
  - x/0 with finite nonzero x → ±inf, `dbz=1`.
  - inf/finite → ±inf, `ovf=0`.
  - 0/nonzero and finite/inf → ±0.
- `rst` in any state: IDLE next edge; in-flight operation discarded, nothing output.

## Timing
- Reset values: `in_ready=1`, `out_valid=0`, `y=0`, `ovf=0`, `dbz=0`. Internal registers are cleared.
- Normal latency: `out_valid` rises exactly 28 edges after the accepting edge (26 DIV + 1 ROUND + 1 to DONE).
- Special-case latency: 2 edges when `FDIV_FAST_SPECIAL_EN` is defined.
- Throughput: one operation per 29 cycles when `out_ready` is held at 1.
- `y`, `ovf`, `dbz` are registered and stable while `out_valid=1`. They change only after the output handshake or on reset.
- Back-to-back operation: `in_ready` rises the edge after the output handshake.

## Configuration
- `FDIV_FAST_SPECIAL_EN`
  - Defined: special cases are detected at accept and go IDLE→ROUND, giving a latency of 2.
  - Undefined: every operand pair runs all 26 DIV cycles and the special result overrides the result in ROUND, giving a fixed latency of 28. This is for schedulers that rely on a fixed latency.

## Structure
- `fpu_pkg` holds the items shared with `fadd` and later FPU blocks:
  - field widths (`EXP_W=8`, `MAN_W=23`);
  - `FP_QNAN=32'h7FC00000` and `FP_INF_EXP=8'hFF`;
  - a packed struct `fp32_t`;
  - the `fdiv_state_t` enum.
- One sub-module, `fpu_round_pack`: combinational RNE rounding, overflow/underflow clamping, and packing. Inputs are sign, exponent, 24-bit mantissa, guard and sticky; outputs are `y` and `ovf`. It is reusable by a future `fmul`.

## Test plan
- 6.0/2.0 (`0x40C00000`/`0x40000000`) → `y=0x40400000`, `ovf=0`, `dbz=0`; `out_valid` 28 edges after accept.
- 1.0/3.0 (`0x3F800000`/`0x40400000`) → `0x3EAAAAAB` (RNE round-up). −7.5/2.5 (`0xC0F00000`/`0x40200000`) → `0xC0400000`.
- 1.0/0.0 → `0x7F800000`, `dbz=1`. 0.0/0.0 → `0x7FC00000`, `dbz=0`. Latency is 2 with the macro defined and 28 without it.
- 2^127/0.25 (`0x7F000000`/`0x3E800000`) → `0x7F800000`, `ovf=1`.
- Hold `out_ready=0` for 5 cycles after `out_valid`: `y` stays stable and `in_ready` stays 0. After the handshake, `in_ready=1` on the next edge.
- Assert `rst` for 1 cycle at DIV cycle 10: the next edge shows `in_ready=1`, `out_valid=0`, and no result is produced for that operation. A new 6.0/2.0 issued afterwards completes correctly.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single field widths, special encodings,
// the fp32_t operand view and the fdiv sequencer states.
package fpu_pkg;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;

  localparam logic [31:0]      FP_QNAN    = 32'h7FC00000;
  localparam logic [EXP_W-1:0] FP_INF_EXP = 8'hFF;

  typedef struct packed {
    logic             s;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
  } fp32_t;

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} fdiv_state_t;

endpackage

// File: rtl/fpu_round_pack.sv
// Round-to-nearest-even, overflow/underflow clamping and IEEE single packing
// for a normalised 24-bit mantissa with guard and sticky bits.
module fpu_round_pack
  import fpu_pkg::*;
(
  input  logic              sign,
  input  logic signed [9:0] exp,
  input  logic [MAN_W:0]    man,
  input  logic              guard,
  input  logic              sticky,
  output logic [31:0]       y,
  output logic              ovf
);

  logic               inc;
  logic [MAN_W+1:0]   sum;
  logic signed [9:0]  exp_r;
  logic [MAN_W-1:0]   frac;

  always_comb begin
    inc   = guard & (sticky | man[0]);
    sum   = {1'b0, man} + {{(MAN_W + 1){1'b0}}, inc};
    exp_r = exp;
    frac  = sum[MAN_W-1:0];
    // Mantissa carry-out: 1.111..1 + ulp becomes 1.0 at the next exponent.
    if (sum[MAN_W+1]) begin
      exp_r = exp + 10'sd1;
      frac  = '0;
    end
    y   = {sign, exp_r[EXP_W-1:0], frac};
    ovf = 1'b0;
    if (exp_r >= 10'sd255) begin
      y   = {sign, FP_INF_EXP, {MAN_W{1'b0}}};
      ovf = 1'b1;
    end else if (exp_r <= 10'sd0 || !(sum[MAN_W] | sum[MAN_W+1])) begin
      // Underflow or an unnormalised mantissa would be a denormal: flush.
      y = {sign, {(EXP_W + MAN_W){1'b0}}};
    end
  end

endmodule

// File: rtl/fdiv.sv
// Iterative single-precision divider, one quotient bit per cycle, RNE rounding.
// Define FDIV_FAST_SPECIAL_EN to short-cut special operands straight to rounding.
module fdiv
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf,
  output logic        dbz
);

  fp32_t a, b;
  assign a = x1;
  assign b = x2;

  fdiv_state_t       state_q;
  logic              sign_q;
  logic signed [9:0] exp_q;
  logic [25:0]       rem_q;
  logic [MAN_W:0]    dvs_q;
  logic [25:0]       quo_q;
  logic [4:0]        cnt_q;
  logic              spec_q;
  logic [31:0]       spec_y_q;
  logic              spec_dbz_q;
  logic [31:0]       y_q;
  logic              ovf_q;
  logic              dbz_q;

  // Special-operand classification on the incoming pair (exponent 0 = zero).
  logic        a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
  logic        res_s, spec;
  logic        spec_dbz;
  logic [31:0] spec_y;

  always_comb begin
    res_s    = a.s ^ b.s;
    a_nan    = (a.e == FP_INF_EXP) && (a.m != '0);
    a_inf    = (a.e == FP_INF_EXP) && (a.m == '0);
    a_zero   = (a.e == '0);
    b_nan    = (b.e == FP_INF_EXP) && (b.m != '0);
    b_inf    = (b.e == FP_INF_EXP) && (b.m == '0);
    b_zero   = (b.e == '0);
    spec     = 1'b1;
    spec_dbz = 1'b0;
    spec_y   = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_y = FP_QNAN;
    end else if (a_inf) begin
      spec_y = {res_s, FP_INF_EXP, {MAN_W{1'b0}}};
    end else if (b_zero) begin
      spec_y   = {res_s, FP_INF_EXP, {MAN_W{1'b0}}};
      spec_dbz = 1'b1;
    end else if (a_zero || b_inf) begin
      spec_y = {res_s, {(EXP_W + MAN_W){1'b0}}};
    end else begin
      spec = 1'b0;
    end
  end

  logic signed [9:0] exp_in;
  assign exp_in = $signed({2'b00, a.e}) - $signed({2'b00, b.e}) + 10'sd127;

  // Restoring step: subtract when the partial remainder covers the divisor.
  logic [25:0] dvs_ext, rem_nxt;
  logic        q_bit;

  always_comb begin
    dvs_ext = {2'b00, dvs_q};
    q_bit   = (rem_q >= dvs_ext);
    rem_nxt = (q_bit ? (rem_q - dvs_ext) : rem_q) << 1;
  end

  logic [MAN_W:0]    norm_man;
  logic              norm_g, norm_st;
  logic signed [9:0] norm_exp;

  always_comb begin
    if (quo_q[25]) begin
      norm_man = quo_q[25:2];
      norm_g   = quo_q[1];
      norm_st  = quo_q[0] | (rem_q != '0);
      norm_exp = exp_q;
    end else begin
      norm_man = quo_q[24:1];
      norm_g   = quo_q[0];
      norm_st  = (rem_q != '0);
      norm_exp = exp_q - 10'sd1;
    end
  end

  logic [31:0] rp_y;
  logic        rp_ovf;

  fpu_round_pack u_round_pack (
    .sign   (sign_q),
    .exp    (norm_exp),
    .man    (norm_man),
    .guard  (norm_g),
    .sticky (norm_st),
    .y      (rp_y),
    .ovf    (rp_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      spec_q     <= 1'b0;
      spec_y_q   <= '0;
      spec_dbz_q <= 1'b0;
      y_q        <= '0;
      ovf_q      <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q     <= res_s;
            exp_q      <= exp_in;
            rem_q      <= {2'b00, 1'b1, a.m};
            dvs_q      <= {1'b1, b.m};
            quo_q      <= '0;
            cnt_q      <= 5'd25;
            spec_q     <= spec;
            spec_y_q   <= spec_y;
            spec_dbz_q <= spec_dbz;
`ifdef FDIV_FAST_SPECIAL_EN
            state_q    <= spec ? ROUND : DIV;
`else
            state_q    <= DIV;
`endif
          end
        end
        DIV: begin
          quo_q <= {quo_q[24:0], q_bit};
          rem_q <= rem_nxt;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd0) state_q <= ROUND;
        end
        ROUND: begin
          if (spec_q) begin
            y_q   <= spec_y_q;
            ovf_q <= 1'b0;
            dbz_q <= spec_dbz_q;
          end else begin
            y_q   <= rp_y;
            ovf_q <= rp_ovf;
            dbz_q <= 1'b0;
          end
          state_q <= DONE;
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign y         = y_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_fdiv.sv
// Self-checking bench for fdiv: directed vectors, handshake/reset scenarios and
// randomized operands against an integer-arithmetic reference model.
module tb_fdiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x1 = '0;
  logic [31:0] x2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] y;
  logic        ovf;
  logic        dbz;

  int errors = 0;
  int checks = 0;

`ifdef FDIV_FAST_SPECIAL_EN
  localparam int LatSpec = 2;
`else
  localparam int LatSpec = 28;
`endif
  localparam int LatNorm = 28;

  fdiv dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .ovf       (ovf),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          acc_cyc[$];
  logic [31:0] out_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) acc_cyc.push_back(cyc);
    if (out_valid && out_ready) out_q.push_back(y);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // Reference: quotient bits from integer division of the scaled significands.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, output logic [31:0] ry,
                         output logic rovf, output logic rdbz, output logic rspec);
    logic   s, g, st;
    int     ea, eb, e;
    longint ma, mb, num, q, r, man;
    bit     na, nb, ia, ib, za, zb;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    za = (ea == 0);
    zb = (eb == 0);
    rovf = 1'b0; rdbz = 1'b0; rspec = 1'b1; ry = '0;
    if (na || nb || (za && zb) || (ia && ib)) ry = 32'h7FC00000;
    else if (ia) ry = {s, 8'hFF, 23'h0};
    else if (zb) begin ry = {s, 8'hFF, 23'h0}; rdbz = 1'b1; end
    else if (za || ib) ry = {s, 31'h0};
    else begin
      rspec = 1'b0;
      ma  = longint'({1'b1, a[22:0]});
      mb  = longint'({1'b1, b[22:0]});
      num = ma << 25;
      q   = num / mb;
      r   = num % mb;
      e   = ea - eb + 127;
      if (q >= (longint'(1) << 25)) begin
        man = q >> 2; g = q[1]; st = q[0] | (r != 0);
      end else begin
        man = q >> 1; g = q[0]; st = (r != 0); e = e - 1;
      end
      if (g && (st || man[0])) man = man + 1;
      if (man == (longint'(1) << 24)) begin man = longint'(1) << 23; e = e + 1; end
      if (e >= 255) begin ry = {s, 8'hFF, 23'h0}; rovf = 1'b1; end
      else if (e <= 0) ry = {s, 31'h0};
      else ry = {s, e[7:0], man[22:0]};
    end
  endtask

  // Drives one operation and returns what the DUT produced; lat counts edges
  // from the accepting edge (inclusive) to the edge that raised out_valid.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, output logic [31:0] ry,
                       output logic rovf, output logic rdbz, output int lat);
    int n;
    x1 = a; x2 = b; out_ready = 1'b0; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    ry = y; rovf = ovf; rdbz = dbz;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] rand_fp();
    int unsigned k, e;
    logic [31:0] m;
    k = $urandom_range(0, 15);
    m = $urandom;
    if (k == 0) e = 0;
    else if (k == 1) begin e = 255; if ($urandom_range(0, 1) == 1) m = '0; end
    else if (k < 10) e = $urandom_range(100, 154);
    else e = $urandom_range(1, 254);
    return {m[31], e[7:0], m[22:0]};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (y !== 32'h0) begin errors++; $display("FAIL reset_y: got %h expected 00000000", y); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", dbz); end
  endtask

  task automatic test_basic();
    logic [31:0] ry; logic rovf, rdbz; int lat;
    do_op(32'h40C00000, 32'h40000000, ry, rovf, rdbz, lat);
    checks++; if (ry !== 32'h40400000) begin errors++; $display("FAIL six_by_two_y: got %h expected 40400000", ry); end
    checks++; if (rovf !== 1'b0) begin errors++; $display("FAIL six_by_two_ovf: got %b expected 0", rovf); end
    checks++; if (rdbz !== 1'b0) begin errors++; $display("FAIL six_by_two_dbz: got %b expected 0", rdbz); end
    checks++; if (lat != LatNorm) begin errors++; $display("FAIL six_by_two_latency: got %0d expected %0d", lat, LatNorm); end
    do_op(32'h3F800000, 32'h40400000, ry, rovf, rdbz, lat);
    checks++; if (ry !== 32'h3EAAAAAB) begin errors++; $display("FAIL one_third_y: got %h expected 3eaaaaab", ry); end
    do_op(32'hC0F00000, 32'h40200000, ry, rovf, rdbz, lat);
    checks++; if (ry !== 32'hC0400000) begin errors++; $display("FAIL neg_div_y: got %h expected c0400000", ry); end
  endtask

  task automatic test_special();
    logic [31:0] ry; logic rovf, rdbz; int lat;
    do_op(32'h3F800000, 32'h00000000, ry, rovf, rdbz, lat);
    checks++; if (ry !== 32'h7F800000) begin errors++; $display("FAIL div_zero_y: got %h expected 7f800000", ry); end
    checks++; if (rdbz !== 1'b1) begin errors++; $display("FAIL div_zero_dbz: got %b expected 1", rdbz); end
    checks++; if (lat != LatSpec) begin errors++; $display("FAIL div_zero_latency: got %0d expected %0d", lat, LatSpec); end
    do_op(32'h00000000, 32'h80000000, ry, rovf, rdbz, lat);
    checks++; if (ry !== 32'h7FC00000) begin errors++; $display("FAIL zero_zero_y: got %h expected 7fc00000", ry); end
    checks++; if (rdbz !== 1'b0) begin errors++; $display("FAIL zero_zero_dbz: got %b expected 0", rdbz); end
    checks++; if (lat != LatSpec) begin errors++; $display("FAIL zero_zero_latency: got %0d expected %0d", lat, LatSpec); end
    do_op(32'hFF800000, 32'h40000000, ry, rovf, rdbz, lat);
    checks++; if (ry !== 32'hFF800000 || rovf !== 1'b0) begin errors++; $display("FAIL inf_by_two: got %h/%b expected ff800000/0", ry, rovf); end
    do_op(32'h40000000, 32'hFF800000, ry, rovf, rdbz, lat);
    checks++; if (ry !== 32'h80000000) begin errors++; $display("FAIL two_by_inf: got %h expected 80000000", ry); end
  endtask

  task automatic test_overflow();
    logic [31:0] ry; logic rovf, rdbz; int lat;
    do_op(32'h7F000000, 32'h3E800000, ry, rovf, rdbz, lat);
    checks++; if (ry !== 32'h7F800000) begin errors++; $display("FAIL overflow_y: got %h expected 7f800000", ry); end
    checks++; if (rovf !== 1'b1) begin errors++; $display("FAIL overflow_ovf: got %b expected 1", rovf); end
    do_op(32'h00800000, 32'h4B000000, ry, rovf, rdbz, lat);
    checks++; if (ry !== 32'h00000000 || rovf !== 1'b0) begin errors++; $display("FAIL underflow: got %h/%b expected 00000000/0", ry, rovf); end
  endtask

  task automatic test_backpressure();
    int n;
    x1 = 32'h40C00000; x2 = 32'h40000000; out_ready = 1'b0; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_wait: out_valid got %b expected 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (y !== 32'h40400000 || out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold_%0d: y/out_valid got %h/%b expected 40400000/1", i, y, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready_%0d: got %b expected 0", i, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL post_handshake: in_ready/out_valid got %b/%b expected 1/0", in_ready, out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ry; logic rovf, rdbz; int lat, n; bit seen;
    x1 = 32'h40C00000; x2 = 32'h40000000; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL midreset_state: in_ready/out_valid got %b/%b expected 1/0", in_ready, out_valid); end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    out_ready = 1'b0;
    checks++; if (seen) begin errors++; $display("FAIL midreset_no_output: got out_valid=1 expected none"); end
    do_op(32'h40C00000, 32'h40000000, ry, rovf, rdbz, lat);
    checks++; if (ry !== 32'h40400000 || lat != LatNorm) begin errors++; $display("FAIL midreset_recover: got %h lat %0d expected 40400000 lat %0d", ry, lat, LatNorm); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, e1, e2; logic eo, ed, es;
    int n0, o0, n;
    a1 = 32'h40C00000; b1 = 32'h40000000; a2 = 32'h3F800000; b2 = 32'h40400000;
    ref_div(a1, b1, e1, eo, ed, es);
    ref_div(a2, b2, e2, eo, ed, es);
    n0 = acc_cyc.size(); o0 = out_q.size();
    out_ready = 1'b1; x1 = a1; x2 = b1; in_valid = 1'b1;
    n = 0;
    while (acc_cyc.size() < n0 + 1 && n < 100) begin @(posedge clk); #1; n++; end
    x1 = a2; x2 = b2;
    n = 0;
    while (acc_cyc.size() < n0 + 2 && n < 100) begin @(posedge clk); #1; n++; end
    in_valid = 1'b0;
    n = 0;
    while (out_q.size() < o0 + 2 && n < 100) begin @(posedge clk); #1; n++; end
    out_ready = 1'b0;
    checks++;
    if (acc_cyc.size() < n0 + 2) begin errors++; $display("FAIL b2b_accepts: got %0d expected 2", acc_cyc.size() - n0); end
    else if (acc_cyc[n0+1] - acc_cyc[n0] != 29) begin errors++; $display("FAIL b2b_period: got %0d expected 29", acc_cyc[n0+1] - acc_cyc[n0]); end
    checks++;
    if (out_q.size() < o0 + 2) begin errors++; $display("FAIL b2b_outputs: got %0d expected 2", out_q.size() - o0); end
    else if (out_q[o0] !== e1 || out_q[o0+1] !== e2) begin errors++; $display("FAIL b2b_values: got %h,%h expected %h,%h", out_q[o0], out_q[o0+1], e1, e2); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, ry, ey; logic rovf, rdbz, eo, ed, es; int lat, elat;
    for (int i = 0; i < 40; i++) begin
      a = rand_fp(); b = rand_fp();
      ref_div(a, b, ey, eo, ed, es);
      elat = es ? LatSpec : LatNorm;
      do_op(a, b, ry, rovf, rdbz, lat);
      checks++;
      if (ry !== ey || rovf !== eo || rdbz !== ed || lat != elat) begin
        errors++;
        $display("FAIL random_%0d %h/%h: got y=%h ovf=%b dbz=%b lat=%0d expected y=%h ovf=%b dbz=%b lat=%0d",
                 i, a, b, ry, rovf, rdbz, lat, ey, eo, ed, elat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_special();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
